start_requester: RTL

- Initiator-side partner of the countdown Counter block. It drives Counter's startSignal__ENA/RDY method and watches its busy output.
- Accepts tagged job requests from an upstream client and buffers them in a small FIFO.
- Issues one start per job, measures how many cycles the job runs, and reports tag, cycle count and timeout status on a done method.

---
 rtl/start_requester_pkg.sv | 21 ++
 rtl/start_requester_fifo.sv | 44 ++++
 rtl/start_requester.sv | 120 ++++++++++++
 3 files changed

// File: rtl/start_requester_pkg.sv
// Shared types and helpers for the start_requester job initiator.
package start_requester_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ISSUE  = ST_ISSUE,
    RUN    = ST_RUN,
    REPORT = ST_REPORT
  } state_t;

  // Width of an occupancy count that can represent 0..depth inclusive.
  function automatic int pend_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/start_requester_fifo.sv
// Small registered FIFO; pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate occupancy register.
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     enq,
  input  logic [WIDTH-1:0]         enq_data,
  input  logic                     deq,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointer advance; writes while full and reads while empty are ignored.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (deq && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge CLK) begin
    if (enq && !full) mem[wr_ptr[AW-1:0]] <= enq_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/start_requester.sv
// Queues tagged jobs, starts them one at a time on Counter, times each run
// until Counter's busy drops (or TIMEOUT is reached) and reports the result.
module start_requester
  import start_requester_pkg::*;
#(
  parameter int TAG_WIDTH = 4,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 1000
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         request__ENA,
  input  logic [TAG_WIDTH-1:0]         request_tag,
  output logic                         request__RDY,
  output logic                         startSignal__ENA,
  input  logic                         startSignal__RDY,
  input  logic                         busy,
  input  logic                         busy__RDY,
  output logic                         done__ENA,
  input  logic                         done__RDY,
  output logic [TAG_WIDTH-1:0]         done_tag,
  output logic [CNT_WIDTH-1:0]         done_cycles,
  output logic                         done_timeout,
  output logic [pend_w(DEPTH)-1:0]     pending
);

  state_t               state;
  state_t               state_nxt;
  logic                 full;
  logic                 empty;
  logic [TAG_WIDTH-1:0] head;
  logic [TAG_WIDTH-1:0] tag_r;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 wr_en;
  logic                 issue;
  logic                 busy_low;
  logic                 at_limit;

  // A slot freed by a same-cycle pop is not offered until the next cycle.
  assign request__RDY = !full;
  assign wr_en        = request__ENA && !full;
  assign issue        = (state == ISSUE) && startSignal__RDY;
  assign busy_low     = busy__RDY && !busy;
  assign at_limit     = (cnt == CNT_WIDTH'(TIMEOUT));

  sync_fifo #(
    .WIDTH (TAG_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .nRST     (nRST),
    .enq      (wr_en),
    .enq_data (request_tag),
    .deq      (issue),
    .full     (full),
    .empty    (empty),
    .count    (pending),
    .head     (head)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: a write this cycle counts as "non-empty" so a fresh job
  // reaches ISSUE one cycle after it is enqueued.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty || wr_en) state_nxt = ISSUE;
      ISSUE:   if (startSignal__RDY) state_nxt = RUN;
      RUN:     if (busy_low || at_limit) state_nxt = REPORT;
      REPORT:  if (done__RDY) state_nxt = (!empty || wr_en) ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Method enables decoded from state.
  always_comb begin
    startSignal__ENA = issue;
    done__ENA        = (state == REPORT);
  end

  // Job tag, run-length counter and report registers. Busy-low wins over
  // the limit, and the limit is tested before incrementing so cnt cannot wrap.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      tag_r        <= '0;
      cnt          <= '0;
      done_cycles  <= '0;
      done_timeout <= 1'b0;
    end else if (issue) begin
      tag_r <= head;
      cnt   <= CNT_WIDTH'(1);
    end else if (state == RUN) begin
      if (busy_low) begin
        done_cycles  <= cnt;
        done_timeout <= 1'b0;
      end else if (at_limit) begin
        done_cycles  <= CNT_WIDTH'(TIMEOUT);
        done_timeout <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign done_tag = tag_r;

  a_start_rdy: assert property (@(posedge CLK) disable iff (!nRST)
    startSignal__ENA |-> startSignal__RDY);
  a_pending:   assert property (@(posedge CLK) disable iff (!nRST)
    pending <= (pend_w(DEPTH))'(DEPTH));
  a_done_st:   assert property (@(posedge CLK) disable iff (!nRST)
    done__ENA |-> (state == REPORT));

endmodule
